pwm_decode: RTL and testbench
=============================

# pwm_decode

Receive-side counterpart to the motor PWM generator. It samples an asynchronous PWM waveform and measures the high time and the rising-to-rising period. It reports an 11-bit duty word in the generator's encoding: high for duty+1 cycles of a 2048-cycle frame. It also flags stuck-high and stuck-low lines. It sits on the feedback/loopback path, letting the controller confirm the commanded duty and detect a dead PWM line.

## Interface
- CNT_W, 12, width of the high-time and period counters; the counters saturate at 2^CNT_W-1.
- TIMEOUT, 4095, cycles with no edge before a stuck condition is declared (must be ≤ 2^CNT_W-1).
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; one clock, synchronous, active-high.
- PWM_in  input  1  PWM waveform, asynchronous to clk.
- duty  output  11  decoded duty: high_cycles-1, saturated to 2047; reset value 0.
- period  output  CNT_W  cycles between the last two rising edges; reset value 0.
- valid  output  1  one-cycle pulse when duty/period/stuck flags update; reset value 0.
- stuck_hi  output  1  line high for ≥ TIMEOUT cycles; reset value 0.
- stuck_lo  output  1  line low for ≥ TIMEOUT cycles; reset value 0.

## Operation
- Input conditioning:
  - Two-flop synchronizer s1→s2, plus a delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All three flops reset to 0.
- Counters:
  - hi_cnt counts cycles with s2=1 in the current frame.
  - per_cnt counts all cycles since the last rise.
  - Both saturate; neither wraps.
- State machine:
  - SYNC (reset state): wait for the first rise; no measurement is published. On rise: hi_cnt←1, per_cnt←1, go to HIGH.
  - HIGH: increment both counters. On fall: go to LOW. If per_cnt reaches TIMEOUT: publish stuck_hi, go to STUCK.
  - LOW: increment per_cnt. On rise:
    - duty ← hi_cnt-1, saturated to 11 bits.
    - period ← per_cnt.
    - valid pulses; stuck flags clear.
    - Counters restart at 1; go to HIGH.
    - If per_cnt reaches TIMEOUT: publish stuck_lo, go to STUCK.
  - STUCK: hold the flags. On rise: go to HIGH with counters at 1. On fall from a stuck-high line: go to LOW with per_cnt continuing from its current value.
- Stuck publishing:
  - stuck_hi: duty←2047, period←TIMEOUT, stuck_hi←1, valid pulses once.
  - stuck_lo: duty←0, period←TIMEOUT, stuck_lo←1, valid pulses once.
  - Both flags are never 1 together.
- Outputs are registered and hold between valid pulses.
- rst asserted mid-frame: all state and outputs return to their reset values on the next clk edge; the partial frame is discarded; return to SYNC.

## Timing
- PWM_in edge → rise/fall visible: 2 clk (through the synchronizer).
- Rise detected in LOW → duty, period and valid updated on the next clk edge. Total from a PWM_in rising edge to valid=1: 3 clk.
- period equals the true period exactly (constant synchronizer delay on both edges). hi_cnt equals the true high time exactly.
- Minimum measurable: 1-cycle high and 1-cycle low. Glitches shorter than one clk may be missed. No filtering is applied.
- valid is high for exactly one cycle per frame or stuck event.
- Back-to-back frames with no gap are supported, one result per frame.

## Structure
- Shared package pwm_pkg:
  - typedef state_t {SYNC, HIGH, LOW, STUCK}.
  - localparam DUTY_W=11.
  - localparam FRAME=2048.
- Sub-module sync2: 2-flop synchronizer with synchronous active-high reset, reused for any other asynchronous input.
- Everything else is in pwm_decode.

## Test plan
- Generator drives duty=500 (high 501, low 1547) → after the second rise, duty=500, period=2048, valid pulses once per frame.
- duty=0 (high 1 cycle) and duty=2046 (low 1 cycle) → duty=0 / 2046 respectively; period=2048 in both cases.
- PWM_in held high 5000 cycles after one rise → valid pulses once at per_cnt=4095. Then duty=2047, period=4095, stuck_hi=1. A later rise→fall→rise sequence clears stuck_hi and reports a normal frame.
- PWM_in held low after reset, then low 4095 cycles after a frame → stuck_lo=1, duty=0. The first rise clears stuck_lo on the next published frame.
- Reset asserted during HIGH of a duty=1000 frame → all outputs read 0 the next cycle and the state returns to SYNC. The first post-reset frame does not set valid. The second frame reports duty=1000.
- Duty changed from 200 to 1500 between frames → consecutive valid pulses report 200 then 1500, with no intermediate value.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM feedback decoder.
//   state_t  : decoder FSM states
//   DUTY_W   : width of the duty word (generator encoding)
//   FRAME    : generator frame length in clk cycles
//   duty_sat : converts a high-time count into the generator's duty encoding
package pwm_pkg;

  typedef enum logic [1:0] {SYNC, HIGH, LOW, STUCK} state_t;

  localparam int          DUTY_W = 11;
  localparam int unsigned FRAME  = 2048;

  // The generator drives the line high for duty+1 cycles, so duty = hi-1,
  // clamped to the largest encodable word.
  function automatic logic [DUTY_W-1:0] duty_sat(input int unsigned hi);
    if (hi == 0)
      return '0;
    if (hi - 1 > FRAME - 1)
      return DUTY_W'(FRAME - 1);
    return DUTY_W'(hi - 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d_i : asynchronous input
//   q_o : synchronized output, two clk cycles behind d_i
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pwm_decode.sv
// pwm_decode: measures high time and rise-to-rise period of an asynchronous
// PWM line and reports them in the motor PWM generator's duty encoding.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   PWM_in   : PWM waveform, asynchronous to clk
//   duty     : high_cycles-1, saturated to 2047 (2047 on stuck-high, 0 on stuck-low)
//   period   : cycles between the last two rising edges (TIMEOUT when stuck)
//   valid    : one-cycle pulse whenever duty/period/stuck flags update
//   stuck_hi : line held high for at least TIMEOUT cycles
//   stuck_lo : line held low until TIMEOUT cycles elapsed since the last rise
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PWM_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              stuck_hi,
  output logic              stuck_lo
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  logic             s2, s3_q;
  logic             rise, fall;
  logic [1:0]       arm_q;
  state_t           state_q;
  logic [CNT_W-1:0] hi_q, per_q, hi_inc, per_inc;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (PWM_in),
    .q_o (s2)
  );

  assign rise    = s2 & ~s3_q;
  assign fall    = ~s2 & s3_q;
  assign hi_inc  = (hi_q  == CNT_MAX) ? hi_q  : hi_q  + 1'b1;
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;

  // The synchronizer and delay flops come out of reset at 0, so a line that
  // is already high would look like a rise. arm_q waits until s3 holds a
  // real sample before SYNC accepts its first edge, so a frame cut by reset
  // is never measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q     <= 1'b0;
      arm_q    <= 2'd0;
      state_q  <= SYNC;
      hi_q     <= '0;
      per_q    <= '0;
      duty     <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else begin
      s3_q  <= s2;
      valid <= 1'b0;
      if (arm_q != 2'd3)
        arm_q <= arm_q + 2'd1;

      unique case (state_q)
        SYNC: begin
          if (rise && arm_q == 2'd3) begin
            hi_q    <= CNT_W'(1);
            per_q   <= CNT_W'(1);
            state_q <= HIGH;
          end
        end

        HIGH: begin
          per_q <= per_inc;
          if (fall) begin
            state_q <= LOW;
          end else begin
            hi_q <= hi_inc;
            // per_q counts from the rise, so this fires on the cycle the
            // line has been high for exactly TIMEOUT cycles.
            if (per_q == TO_M1) begin
              duty     <= DUTY_W'(FRAME - 1);
              period   <= TO;
              stuck_hi <= 1'b1;
              stuck_lo <= 1'b0;
              valid    <= 1'b1;
              state_q  <= STUCK;
            end
          end
        end

        LOW: begin
          if (rise) begin
            duty     <= duty_sat(32'(hi_q));
            period   <= per_q;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
            valid    <= 1'b1;
            hi_q     <= CNT_W'(1);
            per_q    <= CNT_W'(1);
            state_q  <= HIGH;
          end else begin
            per_q <= per_inc;
            // Compare against TIMEOUT-1 so this fires only when the count
            // crosses the limit; after a stuck-high the count is already
            // saturated and the next rise simply publishes that frame.
            if (per_q == TO_M1) begin
              duty     <= '0;
              period   <= TO;
              stuck_hi <= 1'b0;
              stuck_lo <= 1'b1;
              valid    <= 1'b1;
              state_q  <= STUCK;
            end
          end
        end

        STUCK: begin
          if (rise) begin
            hi_q    <= CNT_W'(1);
            per_q   <= CNT_W'(1);
            state_q <= HIGH;
          end else begin
            per_q <= per_inc;
            if (s2)
              hi_q <= hi_inc;
            if (fall && stuck_hi)
              state_q <= LOW;
          end
        end

        default: state_q <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode: drives PWM_in as a list of (level, length) segments and
// predicts every published result from whole-segment arithmetic.
module tb_pwm_decode;

  localparam int TIMEOUT = 4095;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PWM_in = 1'b0;
  logic [10:0] duty;
  logic [11:0] period;
  logic        valid, stuck_hi, stuck_lo;

  pwm_decode #(.CNT_W(12), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .PWM_in   (PWM_in),
    .duty     (duty),
    .period   (period),
    .valid    (valid),
    .stuck_hi (stuck_hi),
    .stuck_lo (stuck_lo)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    int shi;
    int slo;
    int at;
  } ev_t;

  ev_t expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int d, input int p, input int shi, input int slo, input int at);
    ev_t e;
    e = '{d, p, shi, slo, at};
    expq.push_back(e);
  endtask

  // Reference model state: a frame is open from an accepted rise until it
  // is published or declared stuck-low.
  bit frame_open = 0;
  bit frame_shi  = 0;
  bit prev_lvl   = 0;
  int rise_cyc   = 0;
  int hi_len     = 0;

  task automatic seg(input bit lvl, input int len);
    int n;
    @(negedge clk);
    PWM_in = lvl;
    n = cyc;
    if (lvl && !prev_lvl) begin
      if (frame_open)
        expect_ev((hi_len - 1 > 2047) ? 2047 : hi_len - 1,
                  (n - rise_cyc > 4095) ? 4095 : n - rise_cyc, 0, 0, n + 3);
      frame_open = 1;
      rise_cyc   = n;
      hi_len     = len;
      frame_shi  = (len >= TIMEOUT);
      if (frame_shi)
        expect_ev(2047, TIMEOUT, 1, 0, n + 2 + TIMEOUT);
    end else if (!lvl && prev_lvl) begin
      if (frame_open && !frame_shi && hi_len + len >= TIMEOUT) begin
        expect_ev(0, TIMEOUT, 0, 1, rise_cyc + 2 + TIMEOUT);
        frame_open = 0;
      end
    end
    prev_lvl = lvl;
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},    valid,    0);
    chk({tag, "_duty"},     duty,     0);
    chk({tag, "_period"},   period,   0);
    chk({tag, "_stuck_hi"}, stuck_hi, 0);
    chk({tag, "_stuck_lo"}, stuck_lo, 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("duty",        duty,     e.duty);
        chk("period",      period,   e.period);
        chk("stuck_hi",    stuck_hi, e.shi);
        chk("stuck_lo",    stuck_lo, e.slo);
        chk("valid_cycle", cyc,      e.at);
      end
    end
  end

  initial begin
    #(20 * 98000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Long idle low in SYNC must not raise stuck_lo or valid.
    seg(0, 4500);

    repeat (3) begin seg(1, 501);  seg(0, 1547); end
    repeat (2) begin seg(1, 1);    seg(0, 2047); end
    repeat (2) begin seg(1, 2047); seg(0, 1);    end
    seg(1, 201);  seg(0, 1847);
    seg(1, 1501); seg(0, 547);

    for (int i = 0; i < 10; i++) begin
      h = $urandom_range(2000, 1);
      l = $urandom_range(3000 - h, 1);
      seg(1, h);
      seg(0, l);
    end

    // Stuck high, then recovery.
    seg(1, 5000); seg(0, 300);
    seg(1, 700);  seg(0, 400);

    // Stuck low after a frame; flag held until the next published frame.
    seg(1, 900);  seg(0, 5000);
    chk("stuck_lo_set",  stuck_lo, 1);
    chk("stuck_lo_duty", duty,     0);
    seg(1, 600);  seg(0, 600);
    chk("stuck_lo_hold", stuck_lo, 1);
    seg(1, 600);  seg(0, 600);

    // Reset in the middle of a high phase of a duty=1000 stream.
    seg(1, 1001); seg(0, 1047);
    seg(1, 500);
    chk("queue_before_reset", expq.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    frame_open = 0;
    seg(1, 501);  seg(0, 1047);
    seg(1, 1001); seg(0, 1047);
    seg(1, 1001); seg(0, 1047);
    seg(1, 10);
    seg(0, 20);

    chk("pending_events", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
